// File: rtl/sensor_print_gen_if.sv
// TX FIFO write port bundle for sensor_print_gen.
// Master drives bytes and write strobes; slave returns the full flag.
interface sensor_print_gen_if;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       fifo_full;

    modport master (
        output tx_data,
        output tx_wr,
        input  fifo_full
    );

    modport slave (
        input  tx_data,
        input  tx_wr,
        output fifo_full
    );
endinterface

// File: rtl/sensor_print_gen.sv
// Formats watch time or humidity/temperature as one ASCII line into the UART TX FIFO.
// Optional SENSOR_PRINT_AUTO_EN: self-trigger a line whenever sec changes in modes 1/3.
module sensor_print_gen #(
    parameter logic [7:0] SEP_CHAR = 8'h3A,
    parameter bit         TERM_CR  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [5:0]          sec,
    input  logic [5:0]          min,
    input  logic [4:0]          hour,
    input  logic [7:0]          humid,
    input  logic [7:0]          temp,
    sensor_print_gen_if.master  tx,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [1:0] s_mode;
    logic [5:0] s_sec;
    logic [5:0] s_min;
    logic [4:0] s_hour;
    logic [7:0] s_humid;
    logic [7:0] s_temp;

    logic [3:0] h1, h0, m1, m0, c1, c0;
    logic [3:0] u2, u1, u0, t2, t1, t0;

    logic [3:0] idx;
    logic [3:0] body_len;
    logic [3:0] last_idx;
    logic       hum_line;
    logic [7:0] line_byte;
    logic       auto_trig;
    logic       go;
    logic       wr;

    function automatic logic [3:0] d_hun(input logic [7:0] v);
        logic [7:0] q;
        q = v / 8'd100;
        return q[3:0];
    endfunction

    function automatic logic [3:0] d_ten(input logic [7:0] v);
        logic [7:0] q;
        q = (v / 8'd10) % 8'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] d_one(input logic [7:0] v);
        logic [7:0] q;
        q = v % 8'd10;
        return q[3:0];
    endfunction

    function automatic logic [7:0] asc(input logic [3:0] d);
        return {4'h3, d};
    endfunction

`ifdef SENSOR_PRINT_AUTO_EN
    logic [5:0] prev_sec;
    logic       armed;

    // armed keeps the first post-reset cycle from seeing a spurious change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_sec <= 6'd0;
            armed    <= 1'b0;
        end else begin
            prev_sec <= sec;
            armed    <= 1'b1;
        end
    end

    assign auto_trig = armed && (sec != prev_sec) &&
                       ((mode == 2'd1) || (mode == 2'd3));
`else
    assign auto_trig = 1'b0;
`endif

    assign go       = (start || auto_trig) && (mode != 2'd2);
    assign hum_line = (s_mode == 2'd3);
    assign body_len = hum_line ? 4'd13 : 4'd8;
    assign last_idx = body_len + (TERM_CR ? 4'd1 : 4'd0);
    assign wr       = (state == SEND) && !tx.fifo_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (go) state_nx = LOAD;
            LOAD: state_nx = SEND;
            SEND: if (wr && (idx == last_idx)) state_nx = FIN;
            FIN:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_mode  <= 2'd0;
            s_sec   <= 6'd0;
            s_min   <= 6'd0;
            s_hour  <= 5'd0;
            s_humid <= 8'd0;
            s_temp  <= 8'd0;
        end else if ((state == IDLE) && go) begin
            s_mode  <= mode;
            s_sec   <= sec;
            s_min   <= min;
            s_hour  <= hour;
            s_humid <= humid;
            s_temp  <= temp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {h1, h0, m1, m0, c1, c0} <= '0;
            {u2, u1, u0, t2, t1, t0} <= '0;
        end else if (state == LOAD) begin
            h1 <= d_ten({3'd0, s_hour});
            h0 <= d_one({3'd0, s_hour});
            m1 <= d_ten({2'd0, s_min});
            m0 <= d_one({2'd0, s_min});
            c1 <= d_ten({2'd0, s_sec});
            c0 <= d_one({2'd0, s_sec});
            u2 <= d_hun(s_humid);
            u1 <= d_ten(s_humid);
            u0 <= d_one(s_humid);
            t2 <= d_hun(s_temp);
            t1 <= d_ten(s_temp);
            t0 <= d_one(s_temp);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= 4'd0;
        end else if (state == LOAD) begin
            idx <= 4'd0;
        end else if (wr) begin
            idx <= idx + 4'd1;
        end
    end

    always_comb begin
        line_byte = 8'h0A;
        if (idx < body_len) begin
            if (hum_line) begin
                case (idx)
                    4'd0:    line_byte = 8'h48;
                    4'd1:    line_byte = 8'h3D;
                    4'd2:    line_byte = asc(u2);
                    4'd3:    line_byte = asc(u1);
                    4'd4:    line_byte = asc(u0);
                    4'd5:    line_byte = 8'h25;
                    4'd6:    line_byte = 8'h20;
                    4'd7:    line_byte = 8'h54;
                    4'd8:    line_byte = 8'h3D;
                    4'd9:    line_byte = asc(t2);
                    4'd10:   line_byte = asc(t1);
                    4'd11:   line_byte = asc(t0);
                    default: line_byte = 8'h43;
                endcase
            end else begin
                case (idx)
                    4'd0:    line_byte = asc(h1);
                    4'd1:    line_byte = asc(h0);
                    4'd2:    line_byte = SEP_CHAR;
                    4'd3:    line_byte = asc(m1);
                    4'd4:    line_byte = asc(m0);
                    4'd5:    line_byte = SEP_CHAR;
                    4'd6:    line_byte = asc(c1);
                    default: line_byte = asc(c0);
                endcase
            end
        end else if (TERM_CR && (idx == body_len)) begin
            line_byte = 8'h0D;
        end
    end

    assign tx.tx_wr   = wr;
    assign tx.tx_data = (state == SEND) ? line_byte : 8'h00;
    assign busy       = (state == LOAD) || (state == SEND);
    assign done       = (state == FIN);

endmodule
